// File: rtl/shapool_pkg.sv
// Shared SHA-256 constants, padding words, epoch timing and round helpers
// for the shapool nonce search engine.
package shapool_pkg;

  localparam int          ROUNDS         = 64;
  localparam int          ROUND_W        = 6;
  localparam logic [5:0]  LAST_ROUND     = 6'd63;
  localparam logic [63:0] PAD_LEN_BLOCK2 = 64'd640;
  localparam logic [63:0] PAD_LEN_DIGEST = 64'd256;

  localparam logic [255:0] SHA_IV =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

  localparam logic [31:0] SHA_K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  // Working variables a..h; a sits in the top word so the packed value
  // lines up with a 256-bit digest (H0 in [255:224]).
  typedef struct packed {
    logic [31:0] a, b, c, d, e, f, g, h;
  } sha_state_t;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  function automatic logic [31:0] bswap32(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

endpackage

// File: rtl/difficulty_map.sv
// Registered decoder: 4-bit difficulty -> 16-bit mask of top d bits set.
module difficulty_map (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  i_difficulty,
  output logic [15:0] o_mask
);

  logic [15:0] r_mask;

  // One-cycle registered decode.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_mask <= '0;
    else       r_mask <= ~(16'hFFFF >> i_difficulty);
  end

  assign o_mask = r_mask;

endmodule

// File: rtl/sha256_round_unit.sv
// One-round-per-clock SHA-256 compressor. Round 0 starts from i_init and
// i_block; o_digest (i_init + final working state) is valid in round 63.
module sha256_round_unit
  import shapool_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         i_en,
  input  logic [5:0]   i_round,
  input  logic [255:0] i_init,
  input  logic [511:0] i_block,
  output logic [255:0] o_digest
);

  sha_state_t  r_st;
  logic [31:0] r_win [16];

  sha_state_t  w_src;
  sha_state_t  w_next;
  logic [31:0] w_win [16];
  logic [31:0] w_new;
  logic [31:0] w_t1;
  logic [31:0] w_t2;
  logic [255:0] w_next_flat;

  // Round datapath: window holds W[t..t+15], so W[t] is always w_win[0].
  always_comb begin
    w_src = (i_round == 6'd0) ? sha_state_t'(i_init) : r_st;
    for (int i = 0; i < 16; i++) begin
      w_win[i] = (i_round == 6'd0) ? i_block[511 - 32*i -: 32] : r_win[i];
    end
    w_new  = ssig1(w_win[14]) + w_win[9] + ssig0(w_win[1]) + w_win[0];
    w_t1   = w_src.h + bsig1(w_src.e) + ch(w_src.e, w_src.f, w_src.g) + SHA_K[i_round] + w_win[0];
    w_t2   = bsig0(w_src.a) + maj(w_src.a, w_src.b, w_src.c);
    w_next.a = w_t1 + w_t2;
    w_next.b = w_src.a;
    w_next.c = w_src.b;
    w_next.d = w_src.c;
    w_next.e = w_src.d + w_t1;
    w_next.f = w_src.e;
    w_next.g = w_src.f;
    w_next.h = w_src.g;
    w_next_flat = w_next;
    for (int i = 0; i < 8; i++) begin
      o_digest[255 - 32*i -: 32] = i_init[255 - 32*i -: 32] + w_next_flat[255 - 32*i -: 32];
    end
  end

  // Advance working registers and slide the message schedule window.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_st <= '0;
      for (int i = 0; i < 16; i++) r_win[i] <= '0;
    end else if (i_en) begin
      r_st <= w_next;
      for (int i = 0; i < 15; i++) r_win[i] <= w_win[i + 1];
      r_win[15] <= w_new;
    end
  end

endmodule

// File: rtl/shapool.sv
// Double-SHA-256 nonce search over POOL_SIZE tracks. Each track hashes
// nonce k in u0 while u1 hashes the H1 of nonce k-1; the first qualifying
// result (lowest track on ties) latches success/nonce and freezes the engine.
module shapool
  import shapool_pkg::*;
#(
  parameter int POOL_SIZE       = 1,
  parameter int POOL_SIZE_LOG2  = 0,
  parameter int BASE_DIFFICULTY = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [255:0] sha_state,
  input  logic [95:0]  message_head,
  input  logic [3:0]   difficulty,
  input  logic [7:0]   nonce_start_MSB,
  output logic         success,
  output logic [31:0]  nonce
);

  localparam int CNT_W = 24 - POOL_SIZE_LOG2;

  logic [5:0]       r_round;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_cnt_prev;
  logic             r_h1_valid;
  logic             r_success;
  logic [31:0]      r_nonce;

  logic [15:0]          w_bm;
  logic [POOL_SIZE-1:0] w_hit;
  logic                 w_epoch_end;
  logic                 w_take;
  logic                 w_found;
  logic [23:0]          w_win_idx;
  logic [31:0]          w_win_nonce;

  // Final digest meets the target: trailing words zero, then masked check
  // on the byte-swapped next word.
  function automatic logic qualifies(input logic [255:0] h, input logic [15:0] bm);
    logic        ok;
    logic [31:0] c;
    ok = 1'b1;
    for (int i = 8 - BASE_DIFFICULTY; i <= 7; i++) begin
      if (h[255 - 32*i -: 32] != 32'd0) ok = 1'b0;
    end
    c = bswap32(h[255 - 32*(7 - BASE_DIFFICULTY) -: 32]);
    if ((c[31:16] & bm) != 16'd0) ok = 1'b0;
    return ok;
  endfunction

  difficulty_map u_dmap (
    .clk          (clk),
    .reset        (reset),
    .i_difficulty (difficulty),
    .o_mask       (w_bm)
  );

  assign w_epoch_end = !r_success && (r_round == LAST_ROUND);
  assign w_take      = w_epoch_end && r_h1_valid && w_found;

  for (genvar t = 0; t < POOL_SIZE; t++) begin : g_track
    logic [31:0]  w_nonce_u0;
    logic [255:0] w_h1;
    logic [255:0] w_h2;
    logic [255:0] r_h1;

    assign w_nonce_u0 = {nonce_start_MSB, (24'(r_cnt) << POOL_SIZE_LOG2) | 24'(t)};

    sha256_round_unit u0 (
      .clk      (clk),
      .reset    (reset),
      .i_en     (!r_success && !w_take),
      .i_round  (r_round),
      .i_init   (sha_state),
      .i_block  ({message_head, w_nonce_u0, 1'b1, 319'd0, PAD_LEN_BLOCK2}),
      .o_digest (w_h1)
    );

    sha256_round_unit u1 (
      .clk      (clk),
      .reset    (reset),
      .i_en     (!r_success && !w_take),
      .i_round  (r_round),
      .i_init   (SHA_IV),
      .i_block  ({r_h1, 1'b1, 191'd0, PAD_LEN_DIGEST}),
      .o_digest (w_h2)
    );

    assign w_hit[t] = qualifies(w_h2, w_bm);

    // Hand the first-hash digest to u1 at each epoch boundary.
    always_ff @(posedge clk or posedge reset) begin
      if (reset)                      r_h1 <= '0;
      else if (w_epoch_end && !w_take) r_h1 <= w_h1;
    end
  end

  // Lowest qualifying track index wins.
  always_comb begin
    w_found   = 1'b0;
    w_win_idx = '0;
    for (int t = POOL_SIZE - 1; t >= 0; t--) begin
      if (w_hit[t]) begin
        w_found   = 1'b1;
        w_win_idx = 24'(t);
      end
    end
    w_win_nonce = {nonce_start_MSB, (24'(r_cnt_prev) << POOL_SIZE_LOG2) | w_win_idx};
  end

  // Round/epoch counters, pipeline valid flag and sticky result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_round    <= '0;
      r_cnt      <= '0;
      r_cnt_prev <= '0;
      r_h1_valid <= 1'b0;
      r_success  <= 1'b0;
      r_nonce    <= '0;
    end else if (w_take) begin
      r_success <= 1'b1;
      r_nonce   <= w_win_nonce;
    end else if (!r_success) begin
      r_round <= r_round + 6'd1;
      if (w_epoch_end) begin
        r_cnt      <= r_cnt + 1'b1;
        r_cnt_prev <= r_cnt;
        r_h1_valid <= 1'b1;
      end
    end
  end

  assign success = r_success;
  assign nonce   = r_nonce;

endmodule

// File: tb/tb_shapool.sv
// Bench for shapool: three engine configurations plus a standalone
// difficulty_map, checked against a plain software double-SHA-256 model.
module tb_shapool;

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  localparam logic [255:0] IV_T =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam logic [255:0] JOB_STATE =
    256'hdc6a3b8d_0c69421a_cb1a5434_e536f7d5_c3c1b9e4_4cbb9b8f_95f0172e_fc48d2df;
  localparam logic [95:0] JOB_HEAD = 96'hdc141787_358b0553_535f0119;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [255:0] st0, st1, st2;
  logic [95:0]  hd0, hd1, hd2;
  logic [3:0]   d0, d1, d2, dm_d;
  logic [7:0]   m0, m1, m2;
  logic         s0, s1, s2;
  logic [31:0]  n0, n1, n2;
  logic [15:0]  dm_bm;

  int n_cmp  = 0;
  int n_fail = 0;

  shapool #(.POOL_SIZE(1), .POOL_SIZE_LOG2(0), .BASE_DIFFICULTY(0)) dut0 (
    .clk(clk), .reset(reset), .sha_state(st0), .message_head(hd0),
    .difficulty(d0), .nonce_start_MSB(m0), .success(s0), .nonce(n0));

  shapool #(.POOL_SIZE(2), .POOL_SIZE_LOG2(1), .BASE_DIFFICULTY(0)) dut1 (
    .clk(clk), .reset(reset), .sha_state(st1), .message_head(hd1),
    .difficulty(d1), .nonce_start_MSB(m1), .success(s1), .nonce(n1));

  shapool #(.POOL_SIZE(1), .POOL_SIZE_LOG2(0), .BASE_DIFFICULTY(1)) dut2 (
    .clk(clk), .reset(reset), .sha_state(st2), .message_head(hd2),
    .difficulty(d2), .nonce_start_MSB(m2), .success(s2), .nonce(n2));

  difficulty_map dmap (.clk(clk), .reset(reset), .i_difficulty(dm_d), .o_mask(dm_bm));

  // ---------------- reference model ----------------
  function automatic logic [31:0] ror(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] compress(input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] v [8];
    logic [31:0] t1, t2;
    logic [255:0] res;
    for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
    for (int i = 16; i < 64; i++)
      w[i] = w[i-16] + w[i-7]
           + (ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3))
           + (ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10));
    for (int j = 0; j < 8; j++) v[j] = hin[255 - 32*j -: 32];
    for (int i = 0; i < 64; i++) begin
      t1 = v[7] + (ror(v[4], 6) ^ ror(v[4], 11) ^ ror(v[4], 25))
         + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[i] + w[i];
      t2 = (ror(v[0], 2) ^ ror(v[0], 13) ^ ror(v[0], 22))
         + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      for (int j = 7; j > 0; j--) v[j] = v[j-1];
      v[4] = v[4] + t1;
      v[0] = t1 + t2;
    end
    for (int j = 0; j < 8; j++) res[255 - 32*j -: 32] = hin[255 - 32*j -: 32] + v[j];
    return res;
  endfunction

  function automatic logic [255:0] double_hash(input logic [255:0] st, input logic [95:0] hd,
                                               input logic [31:0] nc);
    logic [255:0] h1;
    h1 = compress(st, {hd, nc, 1'b1, 319'd0, 64'd640});
    return compress(IV_T, {h1, 1'b1, 191'd0, 64'd256});
  endfunction

  function automatic bit model_qual(input logic [255:0] h, input int bd, input int d);
    logic [31:0] w, c;
    for (int i = 8 - bd; i <= 7; i++)
      if (h[255 - 32*i -: 32] != 32'd0) return 1'b0;
    w = h[255 - 32*(7 - bd) -: 32];
    c = {w[7:0], w[15:8], w[23:16], w[31:24]};
    for (int j = 0; j < d; j++)
      if (c[31 - j]) return 1'b0;
    return 1'b1;
  endfunction

  // First qualifying nonce over max_ep epochs; each epoch covers 2^lg tracks.
  task automatic model_search(input logic [255:0] st, input logic [95:0] hd, input logic [7:0] msb,
                              input int lg, input int bd, input int d, input int max_ep,
                              output bit found, output int ep, output logic [31:0] nc);
    found = 1'b0; ep = -1; nc = '0;
    for (int e = 0; e < max_ep && !found; e++) begin
      for (int t = 0; t < (1 << lg) && !found; t++) begin
        logic [31:0] cand;
        cand = {msb, 24'(e * (1 << lg) + t)};
        if (model_qual(double_hash(st, hd, cand), bd, d)) begin
          found = 1'b1; ep = e; nc = cand;
        end
      end
    end
  endtask

  // ---------------- driver / checker tasks ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic sample(input int which, output logic s, output logic [31:0] n);
    case (which)
      0:       begin s = s0; n = n0; end
      1:       begin s = s1; n = n1; end
      default: begin s = s2; n = n2; end
    endcase
  endtask

  // Counts rising edges from reset release until success, bounded.
  task automatic observe(input int which, input int max_edges, output int hit_edge,
                         output logic [31:0] hit_nonce);
    logic s;
    logic [31:0] n;
    hit_edge = -1; hit_nonce = '0;
    for (int i = 1; i <= max_edges; i++) begin
      @(posedge clk); #1;
      sample(which, s, n);
      if (s === 1'b1) begin hit_edge = i; hit_nonce = n; break; end
    end
  endtask

  task automatic run_job(input string tag, input int which, input logic [255:0] st,
                         input logic [95:0] hd, input logic [7:0] msb, input logic [3:0] d,
                         input int max_ep);
    int lg, bd, ep, hit_edge;
    bit found;
    logic [31:0] exp_n, hit_n, n;
    logic s;
    case (which)
      0:       begin st0 = st; hd0 = hd; m0 = msb; d0 = d; lg = 0; bd = 0; end
      1:       begin st1 = st; hd1 = hd; m1 = msb; d1 = d; lg = 1; bd = 0; end
      default: begin st2 = st; hd2 = hd; m2 = msb; d2 = d; lg = 0; bd = 1; end
    endcase
    model_search(st, hd, msb, lg, bd, int'(d), max_ep, found, ep, exp_n);
    do_reset();
    observe(which, 64 * (max_ep + 1), hit_edge, hit_n);
    check($sformatf("%s found", tag), 32'(hit_edge >= 0), 32'(found));
    if (found && hit_edge >= 0) begin
      check($sformatf("%s edge", tag), 32'(hit_edge), 32'(64 * (ep + 2)));
      check($sformatf("%s nonce", tag), hit_n, exp_n);
      repeat (25) @(posedge clk);
      #1;
      sample(which, s, n);
      check($sformatf("%s hold success", tag), 32'(s), 32'd1);
      check($sformatf("%s hold nonce", tag), n, exp_n);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int hit_edge;
    logic [31:0] hit_n;
    logic [15:0] exp_bm;
    st0 = '0; st1 = '0; st2 = '0; hd0 = '0; hd1 = '0; hd2 = '0;
    d0 = '0; d1 = '0; d2 = '0; m0 = '0; m1 = '0; m2 = '0; dm_d = '0;

    // Reset state of all outputs.
    #12;
    check("reset success0", 32'(s0), 32'd0);
    check("reset nonce0", n0, 32'd0);
    check("reset success1", 32'(s1), 32'd0);
    check("reset bm", 32'(dm_bm), 32'd0);
    @(negedge clk); reset = 1'b0;

    // difficulty_map: value appears one edge after the change.
    dm_d = 4'd3; #1;
    check("bm before edge", 32'(dm_bm), 32'h0000);
    @(posedge clk); #1;
    check("bm d=3", 32'(dm_bm), 32'hE000);
    @(negedge clk); dm_d = 4'd15; @(posedge clk); #1;
    check("bm d=15", 32'(dm_bm), 32'hFFFE);
    @(negedge clk); dm_d = 4'd0; @(posedge clk); #1;
    check("bm d=0", 32'(dm_bm), 32'h0000);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk); dm_d = 4'($urandom_range(0, 15));
      exp_bm = '0;
      for (int j = 0; j < int'(dm_d); j++) exp_bm[15 - j] = 1'b1;
      @(posedge clk); #1;
      check($sformatf("bm rand d=%0d", dm_d), 32'(dm_bm), 32'(exp_bm));
    end

    // Easiest target: first valid result is nonce 0 at edge 128.
    run_job("base0 d0", 0, JOB_STATE, JOB_HEAD, 8'h00, 4'd0, 1);

    // Two tracks tie; track 0 wins.
    run_job("pool2 d0", 1, JOB_STATE, JOB_HEAD, 8'hA5, 4'd0, 1);

    // Asynchronous reset mid-cycle clears held result at once.
    @(posedge clk); #3; reset = 1'b1; #1;
    check("async rst success", 32'(s1), 32'd0);
    check("async rst nonce", n1, 32'd0);
    @(negedge clk); reset = 1'b0;

    // Reset during round 30 of epoch 1, then restart from epoch 0.
    st0 = JOB_STATE; hd0 = JOB_HEAD; m0 = 8'h00; d0 = 4'd0;
    do_reset();
    repeat (94) @(posedge clk);
    #2; reset = 1'b1; #1;
    check("midrst success", 32'(s0), 32'd0);
    check("midrst nonce", n0, 32'd0);
    @(negedge clk); reset = 1'b0;
    observe(0, 128, hit_edge, hit_n);
    check("midrst edge", 32'(hit_edge), 32'd128);
    check("midrst nonce after", hit_n, 32'h00000000);

    // Reference job with one trailing zero word required over 100 epochs.
    run_job("base1 d3 job", 2, JOB_STATE, JOB_HEAD, 8'h00, 4'd3, 100);

    // Random jobs, single track and two tracks.
    for (int k = 0; k < 4; k++) begin
      run_job($sformatf("rand1 %0d", k), 0,
              {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
              {$urandom, $urandom, $urandom}, 8'($urandom), 4'($urandom_range(1, 4)), 40);
    end
    for (int k = 0; k < 3; k++) begin
      run_job($sformatf("rand2 %0d", k), 1,
              {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
              {$urandom, $urandom, $urandom}, 8'($urandom), 4'($urandom_range(1, 4)), 30);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/shapool.md
Name: shapool

Overview:
- Bitcoin-style double-SHA-256 nonce search engine with POOL_SIZE parallel tracks.
- Each track hashes the second header block from a supplied midstate, then hashes the 256-bit digest again. It stops when the final digest meets the difficulty target.
- Sits under the job/SPI front end, which supplies job parameters and reads back success and nonce.
- Includes the companion registered decoder difficulty_map (4-bit difficulty to 16-bit mask).

Parameters:
- POOL_SIZE, 1, number of parallel tracks (power of two).
- POOL_SIZE_LOG2, 0, log2(POOL_SIZE); 0 means no track field in the nonce.
- BASE_DIFFICULTY, 1, number of trailing 32-bit digest words (H7 downward) that must be zero; range 0..7.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- sha_state  in  256  SHA-256 midstate after header block 1; H0 in bits [255:224].
- message_head  in  96  first 3 words of header block 2 (merkle tail, time, bits).
- difficulty  in  4  job difficulty; drives the internal difficulty_map.
- nonce_start_MSB  in  8  per-device nonce[31:24].
- success  out  1  sticky: a qualifying nonce was found.
- nonce  out  32  the qualifying nonce; valid while success=1.

Behaviour:
- difficulty_map:
  - Registered, 1-cycle latency; output resets to 0.
  - bm = ~(16'hFFFF >> d): d=0 -> 0x0000, d=3 -> 0xE000, d=15 -> 0xFFFE.
- Inputs are static during a job; changing them mid-job gives undefined results until reset.
- Nonce for track t:
  - {nonce_start_MSB, cnt[23-POOL_SIZE_LOG2:0], t[POOL_SIZE_LOG2-1:0]}.
  - cnt resets to 0 and increments once per epoch, wrapping mod 2^(24-POOL_SIZE_LOG2).
- Epoch = 64 cycles. A 6-bit round counter runs 0..63 and resets to 0.
- Each track has two one-round-per-clock SHA-256 compressors, u0 and u1. Both run every cycle of an epoch.
- u0 (first hash, block 2):
  - Initial state = sha_state.
  - M = {message_head, nonce_t, 1'b1, 319'b0, 64'd640}; the nonce is inserted as-is (no byte swap).
  - At round 63: H1 = sha_state + final working state (word-wise mod 2^32). H1 is registered into u1's message.
- u1 (second hash):
  - Initial state = SHA-256 IV.
  - M = {H1, 1'b1, 191'b0, 64'd256}.
  - At round 63: H2 = IV + final working state.
- Pipeline:
  - In epoch k, u0 hashes nonce k while u1 hashes H1 of nonce k-1.
  - u1 results from epoch 0 are invalid and suppressed.
- Success rule:
  - Words H2[7] down to H2[8-BASE_DIFFICULTY] are all zero.
  - Let C = byteswap32(H2[7-BASE_DIFFICULTY]); (C[31:16] & difficulty_bm) must be 0.
  - BASE_DIFFICULTY=0: only the mask check applies, on byteswap(H7).
- Reporting:
  - Evaluated on the clock edge that ends a valid u1 epoch.
  - If several tracks qualify, the lowest track index wins.
  - success<=1 and nonce<= that track's u1 nonce (the nonce from the previous epoch).
- After success, all counters and compressors freeze. success, nonce and H1/H2 hold until reset.
- Earliest result: the 128th rising edge after reset release.
- Reset (async, any time including mid-epoch): success=0, nonce=0, round=0, cnt=0, H1/H2 pipeline flags cleared. The engine restarts from epoch 0 on release.

Decomposition:
- Package shapool_pkg:
  - SHA-256 K[0:63] constants and IV.
  - Padding constants 640 and 256.
  - Round-count and epoch-length constants.
- Sub-module sha256_round_unit:
  - Working registers a..h plus a 16-word rolling message schedule.
  - One round per clock; outputs the final state at round 63.
  - Instantiated twice per track.
- difficulty_map is a separate small module inside shapool.

Test Plan:
- difficulty_map: d=0/3/15 -> bm 0x0000/0xE000/0xFFFE one cycle after the change; reset -> 0x0000.
- Job (sha_state dc6a3b8d_0c69421a_cb1a5434_e536f7d5_c3c1b9e4_4cbb9b8f_95f0172e_fc48d2df, head dc141787_358b0553_535f0119), POOL_SIZE=1, MSB=0x00 -> per-nonce u0 H1 and u1 H2 match a software double-SHA-256 model for nonces 0..99.
- BASE_DIFFICULTY=0, difficulty=0 -> success=1 at edge 128 after reset release, nonce=0x00000000; outputs hold thereafter.
- BASE_DIFFICULTY=1, difficulty=3, 100 epochs -> success stays 0 unless the model finds a qualifying nonce; if found, nonce equals the first qualifying model nonce.
- nonce_start_MSB=0xA5, POOL_SIZE=2, BASE_DIFFICULTY=0, difficulty=0 -> success at edge 128, nonce=0xA5000000 (track 0 wins the tie).
- Assert reset at round 30 of epoch 1 -> success/nonce 0 immediately; after release, the first result again appears at edge 128.
